// File: rtl/conv_scheduler.sv
// rtl/conv_scheduler.sv - 3x3 convolution tap scheduler over a 64x64 image
//
// Purpose: walks output pixels row-major and, for each one, issues the nine
// kernel taps of a 3x3 window (kx fastest, ky outer) to the datapath using a
// valid/ready handshake. Each tap carries its SRAM bank/address, or a pad flag
// when it falls outside the image. After the last tap the scheduler waits
// PIPE_LAT cycles for the datapath to commit, then pulses o_exe_finish.
//
// Optional feature: define CONV_SCHED_STALL_CNT_EN to add o_stall_cnt.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_start       start pulse, only looked at in IDLE
//   i_stride      stride (1 or 2)
//   i_dil         dilation (1 or 2)
//   i_tap_ready   datapath accepts the presented tap
//   o_tap_valid   tap request valid (high throughout ISSUE)
//   o_tap_idx     kernel tap index 0..8
//   o_tap_bank    SRAM bank = pixel index [2:0]
//   o_tap_addr    bank address = pixel index [11:3]
//   o_tap_pad     tap outside the image, datapath substitutes 0
//   o_tap_last    tap 8 of the window
//   o_out_addr    output pixel address of the current window
//   o_busy        high whenever not IDLE
//   o_err         illegal stride/dilation was latched
//   o_exe_finish  one-cycle completion pulse
//   o_stall_cnt   (CONV_SCHED_STALL_CNT_EN only) saturating stall cycle count
`timescale 1ns/1ps

module conv_scheduler #(
    parameter int PIPE_LAT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_stride,
    input  logic [2:0]  i_dil,
    input  logic        i_tap_ready,
    output logic        o_tap_valid,
    output logic [3:0]  o_tap_idx,
    output logic [2:0]  o_tap_bank,
    output logic [8:0]  o_tap_addr,
    output logic        o_tap_pad,
    output logic        o_tap_last,
    output logic [11:0] o_out_addr,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_exe_finish
`ifdef CONV_SCHED_STALL_CNT_EN
    ,
    output logic [15:0] o_stall_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int              DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);

    logic [1:0]         r_state;
    logic [2:0]         r_stride;
    logic [2:0]         r_dil;
    logic               r_err;
    logic [5:0]         r_orow;
    logic [5:0]         r_ocol;
    logic [1:0]         r_kx;
    logic [1:0]         r_ky;
    logic [DRAIN_W-1:0] r_drain_cnt;

    logic               w_legal;
    logic               w_issue;
    logic               w_stride2;
    logic [5:0]         w_last_coord;
    logic               w_last_win;
    logic signed [7:0]  w_dil8;
    logic signed [7:0]  w_crow;
    logic signed [7:0]  w_ccol;
    logic signed [7:0]  w_offy;
    logic signed [7:0]  w_offx;
    logic signed [7:0]  w_trow;
    logic signed [7:0]  w_tcol;
    logic               w_pad;
    logic [11:0]        w_pix;
    logic [3:0]         w_idx;
    logic [11:0]        w_oaddr;
    logic               w_oe;

    assign w_legal = ((i_stride == 3'd1) || (i_stride == 3'd2)) &&
                     ((i_dil == 3'd1) || (i_dil == 3'd2));

    assign w_issue      = (r_state == S_ISSUE);
    assign w_stride2    = (r_stride == 3'd2);
    assign w_last_coord = w_stride2 ? 6'd31 : 6'd63;
    assign w_last_win   = (r_orow == w_last_coord) && (r_ocol == w_last_coord);

    // Coordinates are signed 8-bit: the range -2..65 fits, so a negative tap
    // shows up in bit 7 and an overflow past 63 in bit 6, never wrapping into
    // a legal pixel.
    assign w_dil8 = $signed({5'd0, r_dil});
    assign w_crow = w_stride2 ? $signed({1'b0, r_orow, 1'b0}) : $signed({2'b00, r_orow});
    assign w_ccol = w_stride2 ? $signed({1'b0, r_ocol, 1'b0}) : $signed({2'b00, r_ocol});
    assign w_offy = (r_ky == 2'd0) ? -w_dil8 : ((r_ky == 2'd2) ? w_dil8 : 8'sd0);
    assign w_offx = (r_kx == 2'd0) ? -w_dil8 : ((r_kx == 2'd2) ? w_dil8 : 8'sd0);
    assign w_trow = w_crow + w_offy;
    assign w_tcol = w_ccol + w_offx;
    assign w_pad  = w_trow[7] | w_trow[6] | w_tcol[7] | w_tcol[6];
    assign w_pix  = {w_trow[5:0], w_tcol[5:0]};
    assign w_idx  = ({2'b00, r_ky} * 4'd3) + {2'b00, r_kx};

    // Output width is 64 or 32, so row*OW + col is a plain bit concatenation.
    assign w_oaddr = w_stride2 ? {2'b00, r_orow[4:0], r_ocol[4:0]} : {r_orow, r_ocol};

    // Outputs are forced low while reset is asserted so nothing leaks out
    // before the first reset edge has cleared the state.
    assign w_oe = ~i_rst;

    assign o_tap_valid  = w_oe & w_issue;
    assign o_tap_idx    = o_tap_valid ? w_idx : 4'd0;
    assign o_tap_pad    = o_tap_valid & w_pad;
    assign o_tap_bank   = (o_tap_valid && !w_pad) ? w_pix[2:0] : 3'd0;
    assign o_tap_addr   = (o_tap_valid && !w_pad) ? w_pix[11:3] : 9'd0;
    assign o_tap_last   = o_tap_valid & (r_kx == 2'd2) & (r_ky == 2'd2);
    assign o_out_addr   = o_tap_valid ? w_oaddr : 12'd0;
    assign o_busy       = w_oe & (r_state != S_IDLE);
    assign o_err        = w_oe & r_err;
    assign o_exe_finish = w_oe & (r_state == S_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_stride    <= 3'd0;
            r_dil       <= 3'd0;
            r_err       <= 1'b0;
            r_orow      <= 6'd0;
            r_ocol      <= 6'd0;
            r_kx        <= 2'd0;
            r_ky        <= 2'd0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_stride    <= i_stride;
                        r_dil       <= i_dil;
                        r_orow      <= 6'd0;
                        r_ocol      <= 6'd0;
                        r_kx        <= 2'd0;
                        r_ky        <= 2'd0;
                        r_drain_cnt <= '0;
                        if (w_legal) begin
                            r_err   <= 1'b0;
                            r_state <= S_ISSUE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_tap_ready) begin
                        if (r_kx != 2'd2) begin
                            r_kx <= r_kx + 2'd1;
                        end else begin
                            r_kx <= 2'd0;
                            if (r_ky != 2'd2) begin
                                r_ky <= r_ky + 2'd1;
                            end else begin
                                r_ky <= 2'd0;
                                if (w_last_win) begin
                                    r_drain_cnt <= '0;
                                    r_state     <= (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
                                end else if (r_ocol == w_last_coord) begin
                                    r_ocol <= 6'd0;
                                    r_orow <= r_orow + 6'd1;
                                end else begin
                                    r_ocol <= r_ocol + 6'd1;
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CONV_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_stall_cnt <= 16'd0;
        end else if (w_issue && !i_tap_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = w_oe ? r_stall_cnt : 16'd0;
`endif

endmodule

// File: tb/tb_conv_scheduler.sv
// tb/tb_conv_scheduler.sv - scoreboard bench for conv_scheduler
`timescale 1ns/1ps

module tb_conv_scheduler;

    localparam int PIPE_LAT = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [2:0]  i_stride;
    logic [2:0]  i_dil;
    logic        i_tap_ready;
    logic        o_tap_valid;
    logic [3:0]  o_tap_idx;
    logic [2:0]  o_tap_bank;
    logic [8:0]  o_tap_addr;
    logic        o_tap_pad;
    logic        o_tap_last;
    logic [11:0] o_out_addr;
    logic        o_busy;
    logic        o_err;
    logic        o_exe_finish;
`ifdef CONV_SCHED_STALL_CNT_EN
    logic [15:0] o_stall_cnt;
`endif

    conv_scheduler #(.PIPE_LAT(PIPE_LAT)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_stride     (i_stride),
        .i_dil        (i_dil),
        .i_tap_ready  (i_tap_ready),
        .o_tap_valid  (o_tap_valid),
        .o_tap_idx    (o_tap_idx),
        .o_tap_bank   (o_tap_bank),
        .o_tap_addr   (o_tap_addr),
        .o_tap_pad    (o_tap_pad),
        .o_tap_last   (o_tap_last),
        .o_out_addr   (o_out_addr),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_exe_finish (o_exe_finish)
`ifdef CONV_SCHED_STALL_CNT_EN
        ,
        .o_stall_cnt  (o_stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          seq;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   tap_cnt = 0;
    int   last_tap_cyc = 0;
    int   fin_cnt = 0;
    int   fin_cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [3:0] idx, input logic [2:0] bank,
                                       input logic [8:0] addr, input logic pad,
                                       input logic last, input logic [11:0] oaddr);
        return {2'b00, idx, bank, addr, pad, last, oaddr};
    endfunction

    // Expected tap of window w, kernel position t (accepted-tap sequence w*9+t).
    task automatic push(input int w, input int t, input logic [2:0] bank,
                        input logic [8:0] addr, input logic pad, input logic [11:0] oaddr);
        exp_t e;
        e.seq = w * 9 + t;
        e.val = pk(4'(t), bank, addr, pad, (t == 8), oaddr);
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops an expectation whenever the
    // accepted tap's sequence number matches the queue head.
    initial forever begin
        @(negedge i_clk);
        if (!i_rst) begin
            if (i_start && !o_busy) tap_cnt = 0;
            if (o_tap_valid && i_tap_ready) begin
                if (exp_q.size() > 0 && exp_q[0].seq == tap_cnt) begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("tap_seq%0d", mon_e.seq),
                        pk(o_tap_idx, o_tap_bank, o_tap_addr, o_tap_pad, o_tap_last, o_out_addr),
                        mon_e.val);
                end
                tap_cnt++;
                last_tap_cyc = cyc;
            end
            if (o_exe_finish) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {o_tap_valid, o_tap_idx, o_tap_bank, o_tap_addr, o_tap_pad, o_tap_last,
                   o_out_addr, o_busy, o_err, o_exe_finish}, 64'd0);
`ifdef CONV_SCHED_STALL_CNT_EN
        chk({name, "_stall"}, o_stall_cnt, 0);
`endif
    endtask

    task automatic wait_fin(input int budget, input string name);
        int f0;
        int n;
        f0 = fin_cnt;
        n  = 0;
        while (fin_cnt == f0 && n < budget) begin
            step();
            n++;
        end
        chk(name, (fin_cnt != f0), 1);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_stride    = 3'd1;
        i_dil       = 3'd1;
        i_tap_ready = 1'b1;
        repeat (3) step();
        chk_zero("rst_during");
        i_rst = 1'b0;
        step();
        chk_zero("rst_after");

        // Stride 1, dilation 1, full run with datapath always ready.
        push(0, 0, 3'd0, 9'd0, 1'b1, 12'd0);
        push(0, 4, 3'd0, 9'd0, 1'b0, 12'd0);
        push(0, 5, 3'd1, 9'd0, 1'b0, 12'd0);
        push(0, 6, 3'd0, 9'd0, 1'b1, 12'd0);
        push(0, 8, 3'd1, 9'd8, 1'b0, 12'd0);
        push(1, 3, 3'd0, 9'd0, 1'b0, 12'd1);
        push(64, 0, 3'd0, 9'd0, 1'b1, 12'd64);
        push(64, 2, 3'd1, 9'd0, 1'b0, 12'd64);
        push(64, 7, 3'd0, 9'd16, 1'b0, 12'd64);
        push(4095, 0, 3'd6, 9'd503, 1'b0, 12'd4095);
        push(4095, 2, 3'd0, 9'd0, 1'b1, 12'd4095);
        push(4095, 4, 3'd7, 9'd511, 1'b0, 12'd4095);
        push(4095, 6, 3'd0, 9'd0, 1'b1, 12'd4095);
        push(4095, 8, 3'd0, 9'd0, 1'b1, 12'd4095);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("s1_busy_valid", {o_busy, o_tap_valid}, 2'b11);
        wait_fin(40000, "s1_finish_seen");
        chk("s1_tap_count", tap_cnt, 36864);
        chk("s1_finish_latency", fin_cyc - last_tap_cyc, PIPE_LAT + 1);
        chk("s1_idle_after", {o_busy, o_err, o_exe_finish, o_tap_valid}, 4'b0000);
        chk("s1_sb_empty", exp_q.size(), 0);

        // Stride 2, dilation 2, with an ignored illegal start mid-run.
        push(0, 0, 3'd0, 9'd0, 1'b1, 12'd0);
        push(0, 5, 3'd2, 9'd0, 1'b0, 12'd0);
        push(0, 8, 3'd2, 9'd16, 1'b0, 12'd0);
        push(31, 3, 3'd4, 9'd7, 1'b0, 12'd31);
        push(31, 5, 3'd0, 9'd0, 1'b1, 12'd31);
        push(33, 0, 3'd0, 9'd0, 1'b0, 12'd33);
        push(33, 4, 3'd2, 9'd16, 1'b0, 12'd33);
        push(33, 8, 3'd4, 9'd32, 1'b0, 12'd33);
        push(1023, 0, 3'd4, 9'd487, 1'b0, 12'd1023);
        push(1023, 4, 3'd6, 9'd503, 1'b0, 12'd1023);
        push(1023, 8, 3'd0, 9'd0, 1'b1, 12'd1023);
        i_stride = 3'd2;
        i_dil    = 3'd2;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        repeat (100) step();
        i_stride = 3'd3;
        i_dil    = 3'd3;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        chk("s2_start_ignored", {o_busy, o_err, o_tap_valid}, 3'b101);
        wait_fin(12000, "s2_finish_seen");
        chk("s2_tap_count", tap_cnt, 9216);
        chk("s2_finish_latency", fin_cyc - last_tap_cyc, PIPE_LAT + 1);
        chk("s2_err", o_err, 0);
        chk("s2_sb_empty", exp_q.size(), 0);

        // Stall at tap 3, then reset mid-ISSUE and restart.
        i_stride = 3'd1;
        i_dil    = 3'd1;
        push(0, 3, 3'd0, 9'd0, 1'b1, 12'd0);
        push(0, 4, 3'd0, 9'd0, 1'b0, 12'd0);
        push(1, 3, 3'd0, 9'd0, 1'b0, 12'd1);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("st_first", {o_tap_valid, o_tap_idx, o_out_addr}, {1'b1, 4'd0, 12'd0});
        repeat (3) step();
        i_tap_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("st_frozen%0d", i),
                {o_tap_valid, o_tap_idx, o_tap_pad, o_tap_bank, o_tap_addr, o_out_addr},
                {1'b1, 4'd3, 1'b1, 3'd0, 9'd0, 12'd0});
        end
`ifdef CONV_SCHED_STALL_CNT_EN
        chk("st_stall_cnt", o_stall_cnt, 5);
`endif
        i_tap_ready = 1'b1;
        step();
        chk("st_next_tap", {o_tap_valid, o_tap_idx}, {1'b1, 4'd4});
        repeat (10) step();
        i_rst = 1'b1;
        step();
        chk_zero("rst_mid_during");
        chk("rst_mid_sb_empty", exp_q.size(), 0);
        i_rst = 1'b0;
        step();
        chk_zero("rst_mid_after");
        push(0, 0, 3'd0, 9'd0, 1'b1, 12'd0);
        push(0, 1, 3'd0, 9'd0, 1'b1, 12'd0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("restart_first", {o_tap_valid, o_tap_idx, o_out_addr}, {1'b1, 4'd0, 12'd0});
`ifdef CONV_SCHED_STALL_CNT_EN
        chk("restart_stall_clr", o_stall_cnt, 0);
`endif
        repeat (3) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        step();
        chk("restart_sb_empty", exp_q.size(), 0);

        // Illegal parameters go straight to DONE with o_err.
        i_stride = 3'd3;
        i_dil    = 3'd1;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        chk("bad_stride_done", {o_busy, o_err, o_exe_finish, o_tap_valid}, 4'b1110);
        step();
        chk("bad_stride_idle", {o_busy, o_err, o_exe_finish, o_tap_valid}, 4'b0100);
        chk("bad_stride_no_taps", tap_cnt, 0);
        i_stride = 3'd1;
        i_dil    = 3'd0;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        chk("bad_dil_done", {o_busy, o_err, o_exe_finish, o_tap_valid}, 4'b1110);
        step();
        i_stride = 3'd2;
        i_dil    = 3'd1;
        i_start  = 1'b1;
        step();
        i_start = 1'b0;
        chk("good_clears_err", {o_busy, o_err, o_tap_valid}, 3'b101);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 2, meaning cycles from the last accepted tap to datapath result commit.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_start, input, 1 bit: start pulse, sampled only in IDLE.
REQ-005 SHALL have port i_stride, input, 3 bits: decoded stride; legal values are 1 and 2.
REQ-006 SHALL have port i_dil, input, 3 bits: decoded dilation; legal values are 1 and 2.
REQ-007 SHALL have port i_tap_ready, input, 1 bit: datapath accepts the current tap.
REQ-008 SHALL have port o_tap_valid, output, 1 bit: tap request valid.
REQ-009 SHALL have port o_tap_idx, output, 4 bits: kernel tap index 0..8.
REQ-010 SHALL have port o_tap_bank, output, 3 bits: SRAM bank, equal to pixel index [2:0].
REQ-011 SHALL have port o_tap_addr, output, 9 bits: bank address, equal to pixel index [11:3].
REQ-012 SHALL have port o_tap_pad, output, 1 bit: tap is out of image; datapath uses 0.
REQ-013 SHALL have port o_tap_last, output, 1 bit: tap 8 of the current window.
REQ-014 SHALL have port o_out_addr, output, 12 bits: output pixel address of the current window.
REQ-015 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port o_err, output, 1 bit: illegal parameters were latched.
REQ-017 SHALL have port o_exe_finish, output, 1 bit: one-cycle completion pulse.

Function
REQ-018 SHALL operate on a 64x64 image; pixel index = row*64 + col.
REQ-019 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-020 SHALL, in IDLE on i_start=1, latch i_stride and i_dil and move to ISSUE; with an illegal stride or dilation it SHALL instead move to DONE and set o_err.
REQ-021 SHALL ignore i_start in every state except IDLE.
REQ-022 SHALL size the output as OW = 64/stride per side and scan output pixels row-major; o_out_addr = orow*OW + ocol.
REQ-023 SHALL place the window centre at (orow*stride, ocol*stride).
REQ-024 SHALL issue taps kx-fastest, ky-outer, with tap coordinate = centre + (k-1)*dil and idx = ky*3 + kx.
REQ-025 SHALL set o_tap_pad=1 when the tap row or col is <0 or >63; o_tap_bank and o_tap_addr SHALL then be 0.
REQ-026 SHALL keep o_tap_valid high throughout ISSUE; a tap advances only on o_tap_valid & i_tap_ready.
REQ-027 SHALL hold every tap output stable while i_tap_ready=0.
REQ-028 SHALL present the next tap in the cycle after acceptance, with no bubbles, including across window boundaries.
REQ-029 SHALL hold o_out_addr constant for all 9 taps of a window.
REQ-030 SHALL enter DRAIN in the cycle after the final tap (window OW*OW-1, tap 8) is accepted; o_tap_valid SHALL be 0 there.
REQ-031 SHALL stay in DRAIN for PIPE_LAT cycles, then enter DONE.
REQ-032 SHALL pulse o_exe_finish for the single DONE cycle, then return to IDLE; o_err SHALL hold until the next accepted i_start.
REQ-033 SHALL compute coordinates in signed 8-bit arithmetic, so that no negative tap wraps into a valid index.

Reset
REQ-034 SHALL, on i_rst=1 at a clock edge (including mid-ISSUE or mid-DRAIN), enter IDLE and clear all counters and latched parameters.
REQ-035 SHALL drive every output to 0 during and immediately after reset.

Configuration
REQ-036 SHALL, when macro CONV_SCHED_STALL_CNT_EN is defined, add output o_stall_cnt (16 bits, saturating), counting cycles with o_tap_valid=1 and i_tap_ready=0; it SHALL be cleared on accepted i_start and on reset.
REQ-037 SHALL, without CONV_SCHED_STALL_CNT_EN, omit o_stall_cnt and its logic entirely; all other behaviour SHALL be identical.

Verification
REQ-038 Stride 1, dil 1, i_tap_ready=1 -> first window out_addr 0: tap0 pad=1, tap4 bank0/addr0, tap8 bank1/addr8; exactly 36864 taps, o_exe_finish PIPE_LAT+1 cycles after the last tap.
REQ-039 Stride 2, dil 2 -> window out_addr 33 (centre 2,2): tap0 bank0/addr0 pad=0, tap8 index 260 = bank4/addr32; 9216 taps total.
REQ-040 i_tap_ready low 5 cycles at tap 3 -> outputs frozen for 5 cycles, tap 4 follows immediately after; with the macro defined, o_stall_cnt=5.
REQ-041 i_stride=3 -> IDLE->DONE, o_err=1, o_exe_finish pulses, no o_tap_valid.
REQ-042 i_rst=1 during ISSUE -> next cycle IDLE, all outputs 0; a new i_start restarts at out_addr 0, tap 0.
REQ-043 i_start pulsed during ISSUE -> ignored; tap sequence and latched parameters unchanged.
